mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmit peripheral sitting downstream of the multi-cycle RISC-V core, on the same adr/writedata/memwrite/readdata bus as the instruction/data memory.
- The core writes bytes into a small TX FIFO; an FSM serialises them as 8N1 frames on the `tx` pin.
- Status (busy/full/empty/count/overflow) is readable combinationally, because the core samples readdata in the same cycle it drives adr.
- The top level uses `sel` to steer readdata and to gate memwrite away from main memory.

---
 rtl/mmio_uart_tx.sv | 165 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Status reads are combinational so the core can sample them in the same cycle it drives adr.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_8000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          DEPTH        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr,
  input  logic [31:0] wd,
  input  logic        we,
  output logic        sel,
  output logic [31:0] rd,
  output logic        tx,
  output logic        irq_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          overflow;

  logic [1:0]    offset;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          ovf_clear;
  logic          busy;
  logic [31:0]   status;
  logic          unused_bits;

  assign sel       = (adr[31:4] == BASE_ADDR[31:4]);
  assign offset    = adr[3:2];
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign push_req  = we && sel && (offset == 2'd0);
  assign push      = push_req && !full;
  assign ovf_clear = we && sel && (offset == 2'd1) && wd[3];
  // The FSM takes the head either from IDLE or on the final STOP cycle, giving gapless frames.
  assign pop       = !empty && ((state == IDLE) || ((state == STOP) && (baud_cnt == BAUD_LAST)));
  assign busy      = (state != IDLE) || !empty;
  assign unused_bits = ^{adr[1:0], wd[31:8]};

  always_comb begin
    status            = '0;
    status[0]         = busy;
    status[1]         = full;
    status[2]         = empty;
    status[3]         = overflow;
    status[8 +: AW+1] = count;
  end

  always_comb begin
    rd = '0;
    if (sel && (offset == 2'd1)) rd = status;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (push_req && full) overflow <= 1'b1;
      else if (ovf_clear)   overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wd[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      tx        <= 1'b1;
      irq_empty <= 1'b1;
    end else begin
      irq_empty <= empty && (state == IDLE);
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random traffic, checked every cycle against
// a frame-level model (byte queue + position within the 10-bit frame).
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_8000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wd;
  logic        sel;
  logic [31:0] rd;
  logic        tx;
  logic        irq_empty;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_valid  = 0;
  bit         m_active = 0;
  int         m_pos    = 0;
  logic [7:0] m_cur    = '0;
  bit         m_ovf    = 0;
  logic       m_irq    = 1'b1;

  logic [31:0] rd_seen;
  logic        sel_seen;

  mmio_uart_tx #(
    .BASE_ADDR(BASE),
    .CLKS_PER_BIT(CPB),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .adr(adr),
    .wd(wd),
    .we(we),
    .sel(sel),
    .rd(rd),
    .tx(tx),
    .irq_empty(irq_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s       = '0;
    s[0]    = m_active || (q.size() != 0);
    s[1]    = (q.size() == DEPTH);
    s[2]    = (q.size() == 0);
    s[3]    = m_ovf;
    s[10:8] = 3'(q.size());
    return s;
  endfunction

  function automatic logic model_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  task automatic model_update(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    int  sz;
    bit  full_pre;
    bit  idle_empty;
    bit  at_end;
    bit  do_pop;
    bit  hit;
    sz         = q.size();
    full_pre   = (sz == DEPTH);
    idle_empty = (sz == 0) && !m_active;
    at_end     = m_active && (m_pos == FRAME - 1);
    do_pop     = (sz > 0) && (!m_active || at_end);
    hit        = ((a >> 4) == (BASE >> 4));
    if (r) begin
      q.delete();
      m_active = 0;
      m_pos    = 0;
      m_ovf    = 0;
      m_irq    = 1'b1;
      m_valid  = 1;
    end else begin
      if (m_active) begin
        if (at_end) begin
          if (do_pop) begin
            m_cur = q.pop_front();
            m_pos = 0;
          end else begin
            m_active = 0;
          end
        end else begin
          m_pos++;
        end
      end else if (do_pop) begin
        m_cur    = q.pop_front();
        m_active = 1;
        m_pos    = 0;
      end
      if (w && hit && a[3:2] == 2'd0) begin
        if (full_pre) m_ovf = 1;
        else q.push_back(d[7:0]);
      end
      if (w && hit && a[3:2] == 2'd1 && d[3]) m_ovf = 0;
      m_irq = idle_empty;
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, then check registered ones after the edge.
  task automatic apply_stimulus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic sel_exp;
    @(negedge clk);
    reset = r;
    we    = w;
    adr   = a;
    wd    = d;
    #1;
    rd_seen  = rd;
    sel_seen = sel;
    if (m_valid) begin
      sel_exp = ((a >> 4) == (BASE >> 4));
      check_output($sformatf("sel@%0d", cyc), 32'(sel), 32'(sel_exp));
      check_output($sformatf("rd@%0d", cyc), rd,
                   (sel_exp && a[3:2] == 2'd1) ? model_status() : 32'h0);
    end
    @(posedge clk);
    model_update(r, w, a, d);
    #1;
    cyc++;
    if (m_valid) begin
      check_output($sformatf("tx@%0d", cyc), 32'(tx), 32'(model_tx()));
      check_output($sformatf("irq_empty@%0d", cyc), 32'(irq_empty), 32'(m_irq));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, BASE + 32'h4, 32'h0);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((m_active || q.size() != 0) && k < budget) begin
      idle(1);
      k++;
    end
    if (m_active || q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL wait_idle: still busy after %0d cycles, required idle", budget);
    end
  endtask

  initial begin
    int k;
    logic [31:0] a;
    reset = 1'b1;
    we    = 1'b0;
    adr   = '0;
    wd    = '0;

    // Reset and idle state
    apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0);
    idle(3);
    check_output("reset_status", rd_seen, 32'h4);

    // Single frame 0xA5
    apply_stimulus(1'b0, 1'b1, BASE, 32'hA5);
    idle(10);
    check_output("t1_busy", 32'(rd_seen[0]), 32'h1);
    idle(40);
    check_output("t1_idle_status", rd_seen, 32'h4);

    // Three back-to-back frames
    apply_stimulus(1'b0, 1'b1, BASE, 32'h01);
    apply_stimulus(1'b0, 1'b1, BASE, 32'h02);
    apply_stimulus(1'b0, 1'b1, BASE, 32'h03);
    idle(1);
    check_output("t2_count2", 32'(rd_seen[10:8]), 32'h2);
    wait_idle(200);

    // Overflow: six writes into a depth-4 FIFO
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b1, BASE, 32'h10 + 32'(i));
    idle(1);
    check_output("t3_full", 32'(rd_seen[1]), 32'h1);
    check_output("t3_ovf", 32'(rd_seen[3]), 32'h1);
    apply_stimulus(1'b0, 1'b1, BASE + 32'h4, 32'h8);
    idle(1);
    check_output("t3_ovf_clear", 32'(rd_seen[3]), 32'h0);
    wait_idle(300);

    // Reset in the middle of data bit 3 with more bytes queued
    apply_stimulus(1'b0, 1'b1, BASE, 32'h3C);
    apply_stimulus(1'b0, 1'b1, BASE, 32'h11);
    apply_stimulus(1'b0, 1'b1, BASE, 32'h22);
    k = 0;
    while (!(m_active && m_pos == 17) && k < 50) begin
      idle(1);
      k++;
    end
    check_output("t4_reached_bit3", 32'(m_active && m_pos == 17), 32'h1);
    apply_stimulus(1'b1, 1'b0, BASE + 32'h4, 32'h0);
    idle(1);
    check_output("t4_status", rd_seen, 32'h4);
    idle(60);

    // Address decode and reserved offsets
    apply_stimulus(1'b0, 1'b1, BASE, 32'h5A);
    apply_stimulus(1'b0, 1'b1, BASE, 32'h6B);
    apply_stimulus(1'b0, 1'b1, BASE + 32'h8, 32'h77);
    check_output("t5_rd_8", rd_seen, 32'h0);
    apply_stimulus(1'b0, 1'b1, BASE + 32'hC, 32'h78);
    check_output("t5_rd_c", rd_seen, 32'h0);
    check_output("t5_sel_c", 32'(sel_seen), 32'h1);
    apply_stimulus(1'b0, 1'b1, 32'h0000_0100, 32'h79);
    check_output("t5_sel_100", 32'(sel_seen), 32'h0);
    check_output("t5_rd_100", rd_seen, 32'h0);
    apply_stimulus(1'b0, 1'b1, 32'h0000_8010, 32'h7A);
    check_output("t5_sel_8010", 32'(sel_seen), 32'h0);
    idle(1);
    check_output("t5_count", 32'(rd_seen[10:8]), 32'h1);
    wait_idle(200);

    // Push into a full FIFO on the same edge as the STOP-end pop
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, BASE, 32'hC0 + 32'(i));
    k = 0;
    while (!(m_active && m_pos == FRAME - 1 && q.size() == DEPTH) && k < 80) begin
      idle(1);
      k++;
    end
    check_output("t6_reached_stop_end", 32'(m_pos == FRAME - 1 && q.size() == DEPTH), 32'h1);
    apply_stimulus(1'b0, 1'b1, BASE, 32'hEE);
    idle(1);
    check_output("t6_ovf", 32'(rd_seen[3]), 32'h1);
    check_output("t6_count", 32'(rd_seen[10:8]), 32'(DEPTH - 1));
    wait_idle(300);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    a = BASE;
        2:       a = BASE + 32'h4;
        3:       a = BASE + 32'h8;
        4:       a = BASE + 32'hC;
        5:       a = 32'h0000_0100;
        6:       a = BASE + 32'h10;
        default: a = $urandom;
      endcase
      a = a | 32'($urandom_range(0, 3));
      apply_stimulus(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 2) == 0), a, $urandom);
    end
    wait_idle(400);
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
